wb_unit: RTL

//  Write-back end of the RV32I register file write port: merges execute results (ALU/LUI/JAL) and
//  out-of-band load responses into one registered regfile write (wr_en/write_reg_num/write_data).

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_tag_fifo.sv | 64 ++++++
 rtl/wb_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared write-back types: result source select, load tag layout, default data width.
package wb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LUI  = 2'd1,
    WB_JUMP = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       lb;
    logic [1:0] byte_off;
  } ld_tag_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// In-order tag FIFO for outstanding loads; pop is same-cycle, push lands next cycle.
// Full blocks push (no bypass); every slot is exposed with a valid bit for hazard lookup.
module wb_tag_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  ld_tag_t                i_tag,
  input  logic                   i_pop,
  output ld_tag_t                o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output ld_tag_t [DEPTH-1:0]    o_entries,
  output logic    [DEPTH-1:0]    o_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ld_tag_t [DEPTH-1:0] r_mem;
  logic    [DEPTH-1:0] r_vld;
  logic    [AW-1:0]    r_wptr;
  logic    [AW-1:0]    r_rptr;
  logic    [AW:0]      r_cnt;
  logic                w_push;
  logic                w_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr];
  assign o_entries = r_mem;
  assign o_valid   = r_vld;

  // Push and pop never address the same slot: that needs count==0 (pop blocked) or full (push blocked).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem  <= '0;
      r_vld  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_tag;
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb_unit.sv
// RV32I write-back: merges execute results and in-order load responses into one registered regfile write (1 cycle).
// Loads win, a colliding execute result waits in a 1-entry skid; ex_ready drops on skid full or WAW. Bypass: WB_FORWARD_EN.
module wb_unit
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4,
  parameter int XLEN     = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_src,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alu_data,
  input  logic [XLEN-1:0] imm_val_lui,
  input  logic [XLEN-1:0] return_address,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic            ld_lb,
  input  logic [1:0]      ld_byte_off,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [4:0]      read_reg_num1,
  input  logic [4:0]      read_reg_num2,
  output logic            hazard,
  output logic            wr_en,
  output logic [4:0]      write_reg_num,
  output logic [XLEN-1:0] write_data,
  output logic            resp_err,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data
);

  ld_tag_t                w_tag_in;
  ld_tag_t                w_head;
  ld_tag_t [LD_DEPTH-1:0] w_ent;
  logic    [LD_DEPTH-1:0] w_ent_vld;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_ex_pend;
  logic                   w_hz;
  logic                   w_ex_acc;
  logic    [XLEN-1:0]     w_ex_data;
  logic    [XLEN-1:0]     w_ld_data;
  logic    [7:0]          w_ld_byte;

  logic                   r_wr_en;
  logic    [4:0]          r_wr_num;
  logic    [XLEN-1:0]     r_wr_data;
  logic                   r_skid_vld;
  logic    [4:0]          r_skid_rd;
  logic    [XLEN-1:0]     r_skid_data;
  logic                   r_resp_err;

  assign w_tag_in = '{rd: ld_rd, lb: ld_lb, byte_off: ld_byte_off};
  assign w_pop    = mem_rvalid && !w_empty;

  wb_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (ld_valid),
    .i_tag     (w_tag_in),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_entries (w_ent),
    .o_valid   (w_ent_vld)
  );

  // The retiring head still counts as pending: its write only lands next cycle.
  always_comb begin
    w_ex_pend = 1'b0;
    w_hz      = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (w_ent_vld[i]) begin
        if (w_ent[i].rd == ex_rd) w_ex_pend = 1'b1;
        if (read_reg_num1 != 5'd0 && w_ent[i].rd == read_reg_num1) w_hz = 1'b1;
        if (read_reg_num2 != 5'd0 && w_ent[i].rd == read_reg_num2) w_hz = 1'b1;
      end
    end
  end

  assign hazard   = w_hz;
  assign ld_ready = !w_full;
  assign ex_ready = !r_skid_vld && !(ex_rd != 5'd0 && w_ex_pend);
  assign w_ex_acc = ex_valid && ex_ready;

  always_comb begin
    w_ex_data = ex_alu_data;
    case (wb_src_e'(ex_src))
      WB_LUI:  w_ex_data = imm_val_lui;
      WB_JUMP: w_ex_data = return_address;
      default: w_ex_data = ex_alu_data;
    endcase
  end

  assign w_ld_byte = mem_rdata[{w_head.byte_off, 3'b000} +: 8];
  assign w_ld_data = w_head.lb ? {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte} : mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en     <= 1'b0;
      r_wr_num    <= '0;
      r_wr_data   <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (mem_rvalid && w_empty) r_resp_err <= 1'b1;
      if (w_pop) begin
        r_wr_en   <= (w_head.rd != 5'd0);
        r_wr_num  <= w_head.rd;
        r_wr_data <= w_ld_data;
        if (w_ex_acc) begin
          r_skid_vld  <= 1'b1;
          r_skid_rd   <= ex_rd;
          r_skid_data <= w_ex_data;
        end
      end else if (r_skid_vld) begin
        r_wr_en    <= (r_skid_rd != 5'd0);
        r_wr_num   <= r_skid_rd;
        r_wr_data  <= r_skid_data;
        r_skid_vld <= 1'b0;
      end else if (w_ex_acc) begin
        r_wr_en   <= (ex_rd != 5'd0);
        r_wr_num  <= ex_rd;
        r_wr_data <= w_ex_data;
      end
    end
  end

  assign wr_en         = r_wr_en;
  assign write_reg_num = r_wr_num;
  assign write_data    = r_wr_data;
  assign resp_err      = r_resp_err;

`ifdef WB_FORWARD_EN
  assign fwd1_valid = r_wr_en && (r_wr_num == read_reg_num1) && (read_reg_num1 != 5'd0);
  assign fwd2_valid = r_wr_en && (r_wr_num == read_reg_num2) && (read_reg_num2 != 5'd0);
  assign fwd1_data  = r_wr_data;
  assign fwd2_data  = r_wr_data;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

endmodule
